// File: rtl/n_bit_up_counter_pkg.sv
// ----------------------------------------------------------------------------
// n_bit_up_counter_pkg
//   Shared constants for the free-running up counter and its terminal-count
//   detector. The counter has no other configuration, so this package only
//   holds the width limits and the default width.
// ----------------------------------------------------------------------------
package n_bit_up_counter_pkg;

   localparam int unsigned CNT_N_MIN     = 1;
   localparam int unsigned CNT_N_MAX     = 32;
   localparam int unsigned CNT_N_DEFAULT = 3;

endpackage : n_bit_up_counter_pkg

// File: rtl/n_bit_up_counter_tc_detect.sv
// ----------------------------------------------------------------------------
// up_counter_tc_detect
//   Combinational terminal-count comparator. tc is high while count equals
//   TC_VALUE, which defaults to all-ones for an up counter. A down or modulo
//   counter can reuse it by overriding TC_VALUE.
//
// Ports
//   count  in  [N-1:0]  registered counter value
//   tc     out 1        terminal-count decode
// ----------------------------------------------------------------------------
module up_counter_tc_detect
   import n_bit_up_counter_pkg::*;
#(
   parameter int unsigned    N        = CNT_N_DEFAULT,
   parameter logic [N-1:0]   TC_VALUE = {N{1'b1}}
) (
   input  logic [N-1:0] count,
   output logic         tc
);

   // Decodes a single registered value, so tc only moves on clock or reset.
   always_comb begin
      tc = (count == TC_VALUE);
   end

endmodule : up_counter_tc_detect

// File: rtl/n_bit_up_counter.sv
// ----------------------------------------------------------------------------
// n_bit_up_counter
//   Free-running N-bit binary up counter. Advances on every rising clk edge
//   while out of reset and wraps from all-ones to zero. done flags the
//   all-ones cycle: one clk period wide, once every 2^N cycles.
//
// Ports
//   clk        in  1        counting clock
//   rstn       in  1        asynchronous active-low reset, clears everything
//   done       out 1        high while count_out is all-ones
//   count_out  out [N-1:0]  current count, unsigned
// ----------------------------------------------------------------------------
module n_bit_up_counter
   import n_bit_up_counter_pkg::*;
#(
   parameter int unsigned N = CNT_N_DEFAULT
) (
   input  logic         clk,
   input  logic         rstn,
   output logic         done,
   output logic [N-1:0] count_out
);

   localparam logic [N-1:0] CNT_MAX = {N{1'b1}};

   logic [N-1:0] count_d;
   logic [N-1:0] count_q;
   logic         tc;

   // N-bit add: the carry out of the MSB is dropped, which is the wrap.
   always_comb begin
      count_d = count_q + N'(1);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   up_counter_tc_detect #(
      .N        (N),
      .TC_VALUE (CNT_MAX)
   ) u_tc_detect (
      .count (count_q),
      .tc    (tc)
   );

   // done is taken straight off the decode of the register; reset clears
   // count_q, which makes done 0 without any extra gating.
   always_comb begin
      count_out = count_q;
      done      = tc;
   end

endmodule : n_bit_up_counter

// File: tb/tb_n_bit_up_counter.sv
module tb_n_bit_up_counter;

   logic       clk;
   logic       rstn;
   logic       d3, d1, d4;
   logic [2:0] c3;
   logic [0:0] c1;
   logic [3:0] c4;

   int pass_cnt  = 0;
   int total_cnt = 0;
   bit cmp_en    = 1'b0;

   // Reference: number of counting edges since the last reset release.
   int edges = 0;

   n_bit_up_counter #(.N(3)) dut3 (.clk(clk), .rstn(rstn), .done(d3), .count_out(c3));
   n_bit_up_counter #(.N(1)) dut1 (.clk(clk), .rstn(rstn), .done(d1), .count_out(c1));
   n_bit_up_counter #(.N(4)) dut4 (.clk(clk), .rstn(rstn), .done(d4), .count_out(c4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (rstn) edges = edges + 1;
   always @(negedge rstn) edges = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
   endtask

   // Model: count is edges mod 2^N, done is that value being 2^N-1.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("model_c3", 32'(c3), 32'(edges % 8));
         check("model_d3", 32'(d3), 32'((edges % 8) == 7));
         check("model_c1", 32'(c1), 32'(edges % 2));
         check("model_d1", 32'(d1), 32'((edges % 2) == 1));
         check("model_c4", 32'(c4), 32'(edges % 16));
         check("model_d4", 32'(d4), 32'((edges % 16) == 15));
      end
   end

   initial begin
      int  pulses;
      bit  prev;
      bit  found;
      int  first_done;
      longint t_rise [2];

      rstn = 1'b0;
      #2;
      check("rst_c3", 32'(c3), 0);
      check("rst_d3", 32'(d3), 0);
      check("rst_c1", 32'(c1), 0);
      check("rst_c4", 32'(c4), 0);
      #6 rstn = 1'b1;                    // t=8, between edges
      #4;
      check("pre_edge_c3", 32'(c3), 0);
      cmp_en = 1'b1;

      // Basic count 1..7 and terminal count.
      for (int i = 1; i <= 7; i++) begin
         @(negedge clk);
         check("cnt_c3", 32'(c3), 32'(i));
         check("cnt_d3", 32'(d3), (i == 7) ? 32'd1 : 32'd0);
      end
      @(negedge clk);
      check("wrap_c3", 32'(c3), 0);
      check("wrap_d3", 32'(d3), 0);
      check("n4_mid_c4", 32'(c4), 8);
      check("n1_even_c1", 32'(c1), 0);

      // Asynchronous reset mid-count.
      repeat (3) @(negedge clk);
      check("mid_c3", 32'(c3), 3);
      #2 rstn = 1'b0;
      #1;
      check("async_c3", 32'(c3), 0);
      check("async_d3", 32'(d3), 0);
      check("async_c4", 32'(c4), 0);
      repeat (5) @(negedge clk) check("hold_c3", 32'(c3), 0);

      // Re-release; 200 time units of counting must show two done pulses 80 apart.
      #2 rstn = 1'b1;
      pulses = 0;
      prev   = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (d3 && !prev) begin
            if (pulses < 2) t_rise[pulses] = longint'($time);
            pulses++;
         end
         prev = d3;
      end
      check("pulse_count", 32'(pulses), 2);
      if (pulses >= 2) check("pulse_spacing", 32'(t_rise[1] - t_rise[0]), 80);

      // Reset while done is high.
      found = 1'b0;
      for (int k = 0; k < 16; k++) begin
         if (c3 == 3'd7) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("reach_tc", 32'(found), 1);
      check("tc_d3_high", 32'(d3), 1);
      #2 rstn = 1'b0;
      #1;
      check("rst_at_tc_d3", 32'(d3), 0);
      check("rst_at_tc_c3", 32'(c3), 0);
      @(negedge clk);
      #2 rstn = 1'b1;
      first_done = -1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (d3) begin
            first_done = k;
            break;
         end
      end
      check("first_done_edges", 32'(first_done), 7);

      // N=4 terminal count and wrap; N=1 done tracks count.
      repeat (8) @(negedge clk);
      check("n4_tc_c4", 32'(c4), 15);
      check("n4_tc_d4", 32'(d4), 1);
      check("n1_c1", 32'(c1), 1);
      check("n1_d1", 32'(d1), 1);
      @(negedge clk);
      check("n4_wrap_c4", 32'(c4), 0);
      check("n4_wrap_d4", 32'(d4), 0);
      check("n1_wrap_d1", 32'(d1), 0);

      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule : tb_n_bit_up_counter
